// File: rtl/proc_mem_pkg.sv
// -----------------------------------------------------------------------------
// proc_mem_pkg
//   Shared definitions for the cache-to-memory port arbiter: FSM state
//   encoding, requester identifiers and default line geometry.
// -----------------------------------------------------------------------------
package proc_mem_pkg;

  localparam int LINE_BITS     = 128;
  localparam int LINE_OFF_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Encoding matches the grant_id output: 0 none, 1 dw, 2 dr, 3 ir.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DW   = 2'd1,
    REQ_DR   = 2'd2,
    REQ_IR   = 2'd3
  } req_id_e;

endpackage

// File: rtl/arb_priority_pick.sv
// -----------------------------------------------------------------------------
// arb_priority_pick
//   Combinational winner selection for the memory port. Fixed priority
//   dw > dr > ir, except that a starving iCache jumps the queue.
// Ports
//   dw_req_i, dr_req_i, ir_req_i : requests, already masked by holdoff
//   starve_i                     : iCache has hit its starvation limit
//   grant_o                      : winning requester, REQ_NONE if idle
// -----------------------------------------------------------------------------
module arb_priority_pick
  import proc_mem_pkg::*;
(
  input  logic    dw_req_i,
  input  logic    dr_req_i,
  input  logic    ir_req_i,
  input  logic    starve_i,
  output req_id_e grant_o
);

  always_comb begin
    grant_o = REQ_NONE;
    if (ir_req_i && starve_i) grant_o = REQ_IR;
    else if (dw_req_i)        grant_o = REQ_DW;
    else if (dr_req_i)        grant_o = REQ_DR;
    else if (ir_req_i)        grant_o = REQ_IR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one line-wide memory port between dCache writeback (dw), dCache
//   refill (dr) and iCache refill (ir). One transaction in flight at a time.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for an unmasked request; picks a winner and latches it
//   BUSY    | mem_req held high until mem_ack; read data captured on ack
//   DONE    | one-cycle done/valid pulse to the served requester
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   dw_req_i/addr_i/line_i     : writeback request, address, data; dw_done_o
//   dr_req_i/addr_i            : dCache refill request; dr_valid_o, dr_line_o
//   ir_req_i/addr_i            : iCache refill request; ir_valid_o, ir_line_o
//   mem_req_o/we_o/addr_o/wline_o, mem_rline_i, mem_ack_i : memory side
//   busy_o, grant_id_o         : status (grant_id 0 none, 1 dw, 2 dr, 3 ir)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_BITS     = 32,
  parameter int LINE_BITS     = 128,
  parameter int LINE_OFF_BITS = 4,
  parameter int STARVE_LIMIT  = 4,
  parameter int CNT_BITS      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dw_req_i,
  input  logic [ADDR_BITS-1:0] dw_addr_i,
  input  logic [LINE_BITS-1:0] dw_line_i,
  output logic                 dw_done_o,
  input  logic                 dr_req_i,
  input  logic [ADDR_BITS-1:0] dr_addr_i,
  output logic                 dr_valid_o,
  output logic [LINE_BITS-1:0] dr_line_o,
  input  logic                 ir_req_i,
  input  logic [ADDR_BITS-1:0] ir_addr_i,
  output logic                 ir_valid_o,
  output logic [LINE_BITS-1:0] ir_line_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wline_o,
  input  logic [LINE_BITS-1:0] mem_rline_i,
  input  logic                 mem_ack_i,
  output logic                 busy_o,
  output logic [1:0]           grant_id_o
);

  import proc_mem_pkg::*;

  arb_state_e           state_q;
  req_id_e              grant_q;
  req_id_e              holdoff_q;   // requester served last, masked for one IDLE cycle
  req_id_e              pick;
  logic [CNT_BITS-1:0]  starve_cnt_q, starve_cnt_d;
  logic                 mem_req_q, mem_we_q, busy_q;
  logic                 dw_done_q, dr_valid_q, ir_valid_q;
  logic [ADDR_BITS-1:0] mem_addr_q, sel_addr;
  logic [LINE_BITS-1:0] mem_wline_q, rline_q;
  logic                 dw_m, dr_m, ir_m, starve;

  // Line offset bits never reach memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{dw_addr_i[LINE_OFF_BITS-1:0],
                              dr_addr_i[LINE_OFF_BITS-1:0],
                              ir_addr_i[LINE_OFF_BITS-1:0]};

  assign dw_m   = dw_req_i && (holdoff_q != REQ_DW);
  assign dr_m   = dr_req_i && (holdoff_q != REQ_DR);
  assign ir_m   = ir_req_i && (holdoff_q != REQ_IR);
  assign starve = (starve_cnt_q == CNT_BITS'(STARVE_LIMIT));

  arb_priority_pick u_pick (
    .dw_req_i (dw_m),
    .dr_req_i (dr_m),
    .ir_req_i (ir_m),
    .starve_i (starve),
    .grant_o  (pick)
  );

  always_comb begin
    sel_addr = '0;
    case (pick)
      REQ_DW:  sel_addr = {dw_addr_i[ADDR_BITS-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
      REQ_DR:  sel_addr = {dr_addr_i[ADDR_BITS-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
      REQ_IR:  sel_addr = {ir_addr_i[ADDR_BITS-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
      default: sel_addr = '0;
    endcase
  end

  // Counts dCache grants that pass over a waiting iCache. A held-off iCache
  // can never coincide with a full counter, since an ir grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!ir_req_i || pick == REQ_IR)
        starve_cnt_d = '0;
      else if ((pick == REQ_DW || pick == REQ_DR) && !starve)
        starve_cnt_d = starve_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_NONE;
      holdoff_q    <= REQ_NONE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wline_q  <= '0;
      rline_q      <= '0;
      busy_q       <= 1'b0;
      dw_done_q    <= 1'b0;
      dr_valid_q   <= 1'b0;
      ir_valid_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ST_IDLE: begin
          holdoff_q <= REQ_NONE;
          if (pick != REQ_NONE) begin
            state_q    <= ST_BUSY;
            grant_q    <= pick;
            mem_req_q  <= 1'b1;
            mem_we_q   <= (pick == REQ_DW);
            mem_addr_q <= sel_addr;
            busy_q     <= 1'b1;
            if (pick == REQ_DW) mem_wline_q <= dw_line_i;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            state_q    <= ST_DONE;
            mem_req_q  <= 1'b0;
            if (!mem_we_q) rline_q <= mem_rline_i;
            dw_done_q  <= (grant_q == REQ_DW);
            dr_valid_q <= (grant_q == REQ_DR);
            ir_valid_q <= (grant_q == REQ_IR);
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          holdoff_q  <= grant_q;
          grant_q    <= REQ_NONE;
          busy_q     <= 1'b0;
          dw_done_q  <= 1'b0;
          dr_valid_q <= 1'b0;
          ir_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dw_done_o   = dw_done_q;
  assign dr_valid_o  = dr_valid_q;
  assign ir_valid_o  = ir_valid_q;
  assign dr_line_o   = rline_q;
  assign ir_line_o   = rline_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wline_o = mem_wline_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A single tick() task advances one
//   cycle, samples on the falling edge, models the requesters (drop request
//   on their pulse unless told to keep it) and a memory that acks after a
//   programmable number of BUSY cycles.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AB = 32;
  localparam int LB = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          dw_req_i, dr_req_i, ir_req_i;
  logic [AB-1:0] dw_addr_i, dr_addr_i, ir_addr_i;
  logic [LB-1:0] dw_line_i;
  logic          dw_done_o, dr_valid_o, ir_valid_o;
  logic [LB-1:0] dr_line_o, ir_line_o;
  logic          mem_req_o, mem_we_o;
  logic [AB-1:0] mem_addr_o;
  logic [LB-1:0] mem_wline_o, mem_rline_i;
  logic          mem_ack_i;
  logic          busy_o;
  logic [1:0]    grant_id_o;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .dw_req_i    (dw_req_i),
    .dw_addr_i   (dw_addr_i),
    .dw_line_i   (dw_line_i),
    .dw_done_o   (dw_done_o),
    .dr_req_i    (dr_req_i),
    .dr_addr_i   (dr_addr_i),
    .dr_valid_o  (dr_valid_o),
    .dr_line_o   (dr_line_o),
    .ir_req_i    (ir_req_i),
    .ir_addr_i   (ir_addr_i),
    .ir_valid_o  (ir_valid_o),
    .ir_line_o   (ir_line_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wline_o (mem_wline_o),
    .mem_rline_i (mem_rline_i),
    .mem_ack_i   (mem_ack_i),
    .busy_o      (busy_o),
    .grant_id_o  (grant_id_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int            served_q[$];
  int            tx_gid[$];
  logic          tx_we[$];
  logic [AB-1:0] tx_addr[$];
  logic [LB-1:0] tx_wline[$];
  int            n_dw, n_dr, n_ir, n_multi;
  bit            dw_keep, dr_keep, ir_keep, mem_auto;
  int            ack_dly, wcnt;
  logic [LB-1:0] rline_next;

  task automatic check_eq(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (int'(dw_done_o) + int'(dr_valid_o) + int'(ir_valid_o) > 1) n_multi++;
    if (dw_done_o === 1'b1) begin
      served_q.push_back(1); n_dw++;
      if (!dw_keep) dw_req_i = 1'b0;
    end
    if (dr_valid_o === 1'b1) begin
      served_q.push_back(2); n_dr++;
      if (!dr_keep) dr_req_i = 1'b0;
    end
    if (ir_valid_o === 1'b1) begin
      served_q.push_back(3); n_ir++;
      if (!ir_keep) ir_req_i = 1'b0;
    end
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_auto && mem_req_o === 1'b1) begin
      if (wcnt == ack_dly) begin
        mem_ack_i   = 1'b1;
        mem_rline_i = rline_next;
        tx_gid.push_back(int'(grant_id_o));
        tx_we.push_back(mem_we_o);
        tx_addr.push_back(mem_addr_o);
        tx_wline.push_back(mem_wline_o);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dw_req_i = 1'b0; dr_req_i = 1'b0; ir_req_i = 1'b0;
    dw_keep = 1'b0; dr_keep = 1'b0; ir_keep = 1'b0;
    dw_addr_i = '0; dr_addr_i = '0; ir_addr_i = '0; dw_line_i = '0;
    mem_ack_i = 1'b0; mem_rline_i = '0; mem_auto = 1'b0;
    ack_dly = 0; wcnt = 0; rline_next = '0;
    tick();
    tick();
    rst = 1'b0;
    served_q.delete(); tx_gid.delete(); tx_we.delete();
    tx_addr.delete(); tx_wline.delete();
    n_dw = 0; n_dr = 0; n_ir = 0; n_multi = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_mem_req",  mem_req_o,  0);
    check_eq("rst_busy",     busy_o,     0);
    check_eq("rst_grant",    grant_id_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_line",     dr_line_o,  0);
    check_eq("rst_pulses",   {dw_done_o, dr_valid_o, ir_valid_o}, 0);

    // 1: lone dCache refill, ack in the third BUSY cycle
    mem_auto = 1'b1; ack_dly = 2; rline_next = {16{8'hA5}};
    dr_addr_i = 32'h0000_1234; dr_req_i = 1'b1;
    tick();
    check_eq("t1_mem_req",  mem_req_o,  1);
    check_eq("t1_mem_addr", mem_addr_o, 32'h0000_1230);
    check_eq("t1_mem_we",   mem_we_o,   0);
    check_eq("t1_grant",    grant_id_o, 2);
    check_eq("t1_busy",     busy_o,     1);
    tick(); tick();
    check_eq("t1_ack_cycle_valid", dr_valid_o, 0);
    check_eq("t1_ack_cycle_req",   mem_req_o,  1);
    tick();
    check_eq("t1_dr_valid", dr_valid_o, 1);
    check_eq("t1_dr_line",  dr_line_o,  {16{8'hA5}});
    check_eq("t1_mem_req_low", mem_req_o, 0);
    tick();
    check_eq("t1_valid_one_cycle", dr_valid_o, 0);
    check_eq("t1_idle",            busy_o,     0);

    // 2: three simultaneous requests, one-cycle memory
    do_reset();
    mem_auto = 1'b1; ack_dly = 1; rline_next = {4{32'hC0DE_0001}};
    dw_line_i = {32{4'h1}};
    dw_addr_i = 32'h0000_0100; dr_addr_i = 32'h0000_0204; ir_addr_i = 32'h0000_030C;
    dw_req_i = 1'b1; dr_req_i = 1'b1; ir_req_i = 1'b1;
    for (int i = 0; i < 60 && served_q.size() < 3; i++) tick();
    for (int i = 0; i < 6; i++) tick();
    check_eq("t2_order0", served_q[0], 1);
    check_eq("t2_order1", served_q[1], 2);
    check_eq("t2_order2", served_q[2], 3);
    check_eq("t2_we0",    tx_we[0],    1);
    check_eq("t2_we1",    tx_we[1],    0);
    check_eq("t2_we2",    tx_we[2],    0);
    check_eq("t2_addr0",  tx_addr[0],  32'h0000_0100);
    check_eq("t2_addr1",  tx_addr[1],  32'h0000_0200);
    check_eq("t2_addr2",  tx_addr[2],  32'h0000_0300);
    check_eq("t2_wline0", tx_wline[0], {32{4'h1}});
    check_eq("t2_pulse_counts", {n_dw[7:0], n_dr[7:0], n_ir[7:0]}, 24'h01_01_01);
    check_eq("t2_no_multi", n_multi, 0);
    check_eq("t2_ir_line", ir_line_o, {4{32'hC0DE_0001}});

    // 3a: held dr plus waiting ir -- ir is eligible in dr's holdoff cycle
    do_reset();
    mem_auto = 1'b1; ack_dly = 0;
    dr_keep = 1'b1; dr_req_i = 1'b1; ir_req_i = 1'b1;
    for (int i = 0; i < 40 && tx_gid.size() < 2; i++) tick();
    check_eq("t3a_grant0", tx_gid[0], 2);
    check_eq("t3a_grant1", tx_gid[1], 3);
    dr_keep = 1'b0; dr_req_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 3b: dw and dr both held alternate through each other's holdoff,
    //     so the iCache is passed over until the counter reaches 4
    do_reset();
    mem_auto = 1'b1; ack_dly = 0;
    dw_keep = 1'b1; dr_keep = 1'b1;
    dw_req_i = 1'b1; dr_req_i = 1'b1; ir_req_i = 1'b1;
    for (int i = 0; i < 80 && tx_gid.size() < 4; i++) tick();
    check_eq("t3b_cnt_at_limit", dut.starve_cnt_q, 4);
    for (int i = 0; i < 40 && tx_gid.size() < 5; i++) tick();
    check_eq("t3b_grant0", tx_gid[0], 1);
    check_eq("t3b_grant1", tx_gid[1], 2);
    check_eq("t3b_grant2", tx_gid[2], 1);
    check_eq("t3b_grant3", tx_gid[3], 2);
    check_eq("t3b_grant4", tx_gid[4], 3);
    check_eq("t3b_cnt_cleared", dut.starve_cnt_q, 0);
    dw_keep = 1'b0; dr_keep = 1'b0; dw_req_i = 1'b0; dr_req_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("t3b_drained", busy_o, 0);

    // 4: reset in the second BUSY cycle of an ir read
    do_reset();
    mem_auto = 1'b1; ack_dly = 5; rline_next = {4{32'hDEAD_BEEF}};
    ir_addr_i = 32'h8888_0004; ir_req_i = 1'b1;
    tick();
    check_eq("t4_busy_grant", grant_id_o, 3);
    tick();
    rst = 1'b1; ir_req_i = 1'b0;
    tick();
    check_eq("t4_mem_req_dropped", mem_req_o,  0);
    check_eq("t4_grant_cleared",   grant_id_o, 0);
    check_eq("t4_busy_cleared",    busy_o,     0);
    rst = 1'b0; mem_auto = 1'b0; wcnt = 0;
    mem_rline_i = {4{32'hDEAD_BEEF}}; mem_ack_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("t4_no_ir_valid", n_ir, 0);
    check_eq("t4_line_discarded", ir_line_o, 0);

    // 5: stray ack while idle
    do_reset();
    mem_rline_i = {LB{1'b1}}; mem_ack_i = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_busy",    busy_o,     0);
    check_eq("t5_mem_req", mem_req_o,  0);
    check_eq("t5_grant",   grant_id_o, 0);
    check_eq("t5_pulses",  n_dw + n_dr + n_ir, 0);
    check_eq("t5_line",    dr_line_o,  0);

    // 6: writeback whose inputs change (and request drops) while BUSY
    do_reset();
    mem_auto = 1'b1; ack_dly = 3;
    dw_line_i = {32{4'h1}}; dw_addr_i = 32'h0000_4008; dw_req_i = 1'b1;
    tick();
    check_eq("t6_addr_latched", mem_addr_o,  32'h0000_4000);
    check_eq("t6_we",           mem_we_o,    1);
    check_eq("t6_wline",        mem_wline_o, {32{4'h1}});
    dw_addr_i = 32'h0000_5000; dw_line_i = {32{4'h2}}; dw_req_i = 1'b0;
    tick();
    check_eq("t6_addr_held",  mem_addr_o,  32'h0000_4000);
    check_eq("t6_wline_held", mem_wline_o, {32{4'h1}});
    check_eq("t6_req_held",   mem_req_o,   1);
    for (int i = 0; i < 20 && n_dw < 1; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    check_eq("t6_done_once",  n_dw,        1);
    check_eq("t6_tx_addr",    tx_addr[0],  32'h0000_4000);
    check_eq("t6_tx_wline",   tx_wline[0], {32{4'h1}});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
